// File: rtl/alu_sched_pkg.sv
// Op codes, alu32 timing and shared types for the alu32 scheduler front end.
package alu_sched_pkg;
  localparam logic [7:0] OP_ADD      = 8'h01;
  localparam logic [7:0] OP_SUB      = 8'h02;
  localparam logic [7:0] OP_MUL      = 8'h03;
  localparam int         ALU_MUL_CYC = 4;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP, S_FLUSH} state_t;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  key;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;

  function automatic logic op_known(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction
endpackage

// File: rtl/alu_sched_if.sv
// Requester-side bus of the alu32 scheduler: per-requester request/response lanes.
interface alu_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][7:0]  req_op;
  logic [NREQ-1:0][7:0]  req_key;
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [31:0]           rsp_data;
  logic [7:0]            rsp_key;
  logic                  rsp_err;

  modport master (
    output req_valid, req_op, req_key, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_key, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_key, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_key, rsp_err
  );
endinterface

// File: rtl/alu_sched_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping; one-hot plus index.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);
  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IW'((int'(ptr) + k) % NREQ);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end
endmodule

// File: rtl/alu_sched.sv
// Shares one alu32 (ADD/SUB/MUL) between NREQ requesters: RR grant, operand latch,
// timed alu_en window, result returned with its key to the granted requester.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_CYC = ALU_MUL_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  alu_sched_if.slave  bus,
  output logic        alu_en,
  output logic        alu_clr,
  output logic [7:0]  alu_op,
  output logic [7:0]  alu_key,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic [7:0]  alu_key_out
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MUL_CYC + 1);

  state_t          state, state_n;
  logic [IW-1:0]   ptr, gidx, arb_idx;
  logic [NREQ-1:0] arb_grant;
  logic            arb_any, grant_fire, err_q;
  alu_req_t        lat, sel;
  logic [CW-1:0]   cnt;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign sel = '{op: bus.req_op[arb_idx], key: bus.req_key[arb_idx],
                 a:  bus.req_a[arb_idx],  b:   bus.req_b[arb_idx]};

  assign grant_fire = (state == S_IDLE) && !flush && arb_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      gidx  <= '0;
      lat   <= '0;
      err_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (grant_fire) begin
        lat   <= sel;
        gidx  <= arb_idx;
        err_q <= !op_known(sel.op);
        cnt   <= (sel.op == OP_MUL) ? CW'(MUL_CYC) : CW'(1);
        ptr   <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
      end else if (state == S_EXEC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Outputs are decoded from state; everything idles at zero while rst is high.
  always_comb begin
    state_n       = state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    bus.rsp_key   = '0;
    bus.rsp_err   = 1'b0;
    alu_en        = 1'b0;
    alu_clr       = 1'b0;
    alu_op        = '0;
    alu_key       = '0;
    alu_a         = '0;
    alu_b         = '0;
    if (rst) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush) begin
            state_n = S_FLUSH;
          end else if (arb_any) begin
            bus.req_ready = arb_grant;
            state_n       = op_known(sel.op) ? S_EXEC : S_RESP;
          end
        end
        S_EXEC: begin
          if (flush) begin
            state_n = S_FLUSH;
          end else begin
            alu_en  = 1'b1;
            alu_op  = lat.op;
            alu_key = lat.key;
            alu_a   = lat.a;
            alu_b   = lat.b;
            if (cnt == CW'(1)) state_n = S_RESP;
          end
        end
        S_RESP: begin
          if (flush) begin
            state_n = S_FLUSH;
          end else begin
            // alu32 holds its result while en is low, so pass it straight through.
            bus.rsp_valid[gidx] = 1'b1;
            bus.rsp_err         = err_q;
            bus.rsp_data        = err_q ? 32'd0 : alu_out;
            bus.rsp_key         = err_q ? lat.key : alu_key_out;
            if (bus.rsp_ready[gidx]) state_n = S_IDLE;
          end
        end
        S_FLUSH: begin
          alu_clr = 1'b1;
          state_n = flush ? S_FLUSH : S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: behavioural alu32 stand-in, directed scenarios and random RR traffic.
`timescale 1ns/1ps
module tb_alu_sched;
  import alu_sched_pkg::*;
  localparam int N  = 4;
  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        alu_en, alu_clr;
  logic [7:0]  alu_op, alu_key, alu_key_out;
  logic [31:0] alu_a, alu_b, alu_out;
  int          n_chk = 0;
  int          n_fail = 0;
  int          ptr_m = 0;
  int          mstep = 0;

  alu_sched_if #(.NREQ(N)) bus();

  alu_sched #(.NREQ(N), .MUL_CYC(MC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .alu_en(alu_en), .alu_clr(alu_clr), .alu_op(alu_op), .alu_key(alu_key),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_key_out(alu_key_out)
  );

  always #5 clk = ~clk;

  // alu32 stand-in: ADD/SUB land after one en cycle, MUL after four; out held while en low.
  always @(posedge clk) begin
    if (rst || alu_clr) begin
      alu_out <= 32'd0; alu_key_out <= 8'd0; mstep <= 0;
    end else if (alu_en) begin
      alu_key_out <= alu_key;
      case (alu_op)
        8'h01: alu_out <= alu_a + alu_b;
        8'h02: alu_out <= alu_a - alu_b;
        8'h03: if (mstep == 3) begin alu_out <= alu_a * alu_b; mstep <= 0; end
               else mstep <= mstep + 1;
        default: ;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Reference result, error flag, latency and en-window length for one op.
  task automatic ref_op(input logic [7:0] op, input logic [31:0] a, b,
                        output logic [31:0] d, output logic e, output int lat, output int en);
    e = 1'b0;
    case (op)
      OP_ADD:  begin d = a + b; lat = 2;      en = 1;  end
      OP_SUB:  begin d = a - b; lat = 2;      en = 1;  end
      OP_MUL:  begin d = a * b; lat = MC + 1; en = MC; end
      default: begin d = 32'd0; e = 1'b1; lat = 1; en = 0; end
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; bus.req_valid = '0; bus.rsp_ready = '1;
    repeat (2) tick();
    rst = 1'b0; ptr_m = 0;
    tick();
  endtask

  // Drives one request from IDLE and reports what the DUT did.
  task automatic issue(input int idx, input logic [7:0] op, key, input logic [31:0] a, b,
                       output logic [N-1:0] rdy, output int lat, output int en_cnt,
                       output logic [N-1:0] rv, output logic [31:0] d, output logic [7:0] k,
                       output logic e);
    bus.req_op[idx] = op; bus.req_key[idx] = key; bus.req_a[idx] = a; bus.req_b[idx] = b;
    bus.req_valid = '0; bus.req_valid[idx] = 1'b1; bus.rsp_ready = '1;
    #1; rdy = bus.req_ready;
    tick(); bus.req_valid[idx] = 1'b0; #1;
    lat = 1; en_cnt = 0;
    while (bus.rsp_valid == '0 && lat < 40) begin
      en_cnt += int'(alu_en); tick(); lat++;
    end
    rv = bus.rsp_valid; d = bus.rsp_data; k = bus.rsp_key; e = bus.rsp_err;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; bus.req_valid = '1; bus.rsp_ready = '1;
    for (int i = 0; i < N; i++) begin
      bus.req_op[i] = OP_ADD; bus.req_key[i] = 8'h10; bus.req_a[i] = 32'd1; bus.req_b[i] = 32'd1;
    end
    tick(); tick();
    n_chk++; if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, alu_en, alu_clr} !== '0) begin n_fail++; $display("FAIL reset_ctrl got %b exp 0", {bus.req_ready, bus.rsp_valid, bus.rsp_err, alu_en, alu_clr}); end
    n_chk++; if ({bus.rsp_data, bus.rsp_key, alu_op, alu_key, alu_a, alu_b} !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", {bus.rsp_data, bus.rsp_key, alu_op, alu_key, alu_a, alu_b}); end
    rst = 1'b0; flush = 1'b0; bus.req_valid = '0; ptr_m = 0;
    tick();
    n_chk++; if ({bus.req_ready, bus.rsp_valid, alu_en, alu_clr} !== '0) begin n_fail++; $display("FAIL reset_release got %b exp 0", {bus.req_ready, bus.rsp_valid, alu_en, alu_clr}); end
  endtask

  task automatic test_add();
    logic [N-1:0] rdy, rv; int lat, en; logic [31:0] d; logic [7:0] k; logic e;
    issue(0, OP_ADD, 8'h11, 32'd5, 32'd7, rdy, lat, en, rv, d, k, e);
    n_chk++; if (rdy !== 4'b0001) begin n_fail++; $display("FAIL add_ready got %b exp 0001", rdy); end
    n_chk++; if (lat != 2 || en != 1) begin n_fail++; $display("FAIL add_timing got lat %0d en %0d exp 2 1", lat, en); end
    n_chk++; if ({rv, d, k, e} !== {4'b0001, 32'd12, 8'h11, 1'b0}) begin n_fail++; $display("FAIL add_rsp got %b %h %h %b exp 0001 0000000c 11 0", rv, d, k, e); end
  endtask

  task automatic test_sub_wrap();
    logic [N-1:0] rdy, rv; int lat, en; logic [31:0] d; logic [7:0] k; logic e;
    issue(1, OP_SUB, 8'h33, 32'd0, 32'd1, rdy, lat, en, rv, d, k, e);
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL sub_lat got %0d exp 2", lat); end
    n_chk++; if ({rv, d, k, e} !== {4'b0010, 32'hFFFF_FFFF, 8'h33, 1'b0}) begin n_fail++; $display("FAIL sub_rsp got %b %h %h %b exp 0010 ffffffff 33 0", rv, d, k, e); end
  endtask

  task automatic test_mul();
    logic [N-1:0] rdy, rv; int lat, en; logic [31:0] d; logic [7:0] k; logic e;
    issue(2, OP_MUL, 8'h22, 32'h10000, 32'd3, rdy, lat, en, rv, d, k, e);
    n_chk++; if (rdy !== 4'b0100) begin n_fail++; $display("FAIL mul_ready got %b exp 0100", rdy); end
    n_chk++; if (lat != MC + 1 || en != MC) begin n_fail++; $display("FAIL mul_timing got lat %0d en %0d exp %0d %0d", lat, en, MC + 1, MC); end
    n_chk++; if ({rv, d, k, e} !== {4'b0100, 32'h30000, 8'h22, 1'b0}) begin n_fail++; $display("FAIL mul_rsp got %b %h %h %b exp 0100 00030000 22 0", rv, d, k, e); end
    issue(2, OP_MUL, 8'h23, 32'h1234, 32'h10, rdy, lat, en, rv, d, k, e);
    n_chk++; if ({d, k} !== {32'h12340, 8'h23} || lat != MC + 1) begin n_fail++; $display("FAIL mul2_rsp got %h %h lat %0d exp 00012340 23 %0d", d, k, lat, MC + 1); end
  endtask

  task automatic rr_run(input logic [N-1:0] mask, input int n);
    int got, ex;
    got = 0;
    for (int i = 0; i < N; i++) begin
      bus.req_op[i] = OP_ADD; bus.req_a[i] = i; bus.req_b[i] = 32'd100; bus.req_key[i] = 8'(i);
    end
    bus.req_valid = mask; bus.rsp_ready = '1;
    #1;
    for (int c = 0; c < 60 && got < n; c++) begin
      if (bus.req_ready != '0) begin
        ex = rr_pick(mask, ptr_m);
        n_chk++; if (bus.req_ready !== onehot(ex)) begin n_fail++; $display("FAIL rr_grant got %b exp %b", bus.req_ready, onehot(ex)); end
        ptr_m = (ex + 1) % N; got++;
      end
      tick();
    end
    bus.req_valid = '0;
    n_chk++; if (got != n) begin n_fail++; $display("FAIL rr_count got %0d exp %0d", got, n); end
    repeat (4) tick();
  endtask

  task automatic test_rr();
    do_reset();
    rr_run(4'b1111, 5);
    rr_run(4'b0101, 2);
  endtask

  task automatic test_backpressure_badop();
    int w;
    logic [N-1:0] rdy, rv; int lat, en; logic [31:0] d; logic [7:0] k; logic e;
    bus.req_op[0] = OP_ADD; bus.req_key[0] = 8'h44; bus.req_a[0] = 32'd9; bus.req_b[0] = 32'd1;
    bus.req_op[1] = OP_ADD; bus.req_key[1] = 8'h45; bus.req_a[1] = 32'd1; bus.req_b[1] = 32'd1;
    bus.req_valid = 4'b0001; bus.rsp_ready = 4'b1110;
    #1;
    n_chk++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_ready got %b exp 0001", bus.req_ready); end
    tick(); bus.req_valid = 4'b0010; #1;
    w = 0;
    while (bus.rsp_valid == '0 && w < 10) begin tick(); w++; end
    for (int c = 0; c < 5; c++) begin
      n_chk++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_key, bus.req_ready} !== {4'b0001, 32'd10, 8'h44, 4'b0000}) begin n_fail++; $display("FAIL bp_hold got %b %h %h %b exp 0001 0000000a 44 0000", bus.rsp_valid, bus.rsp_data, bus.rsp_key, bus.req_ready); end
      tick();
    end
    bus.rsp_ready = '1;
    tick();
    n_chk++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_next_grant got %b exp 0010", bus.req_ready); end
    tick(); bus.req_valid = '0;
    repeat (3) tick();
    issue(3, 8'h07, 8'h5A, 32'd123, 32'd456, rdy, lat, en, rv, d, k, e);
    n_chk++; if (lat != 1 || en != 0) begin n_fail++; $display("FAIL badop_timing got lat %0d en %0d exp 1 0", lat, en); end
    n_chk++; if ({rv, d, k, e} !== {4'b1000, 32'd0, 8'h5A, 1'b1}) begin n_fail++; $display("FAIL badop_rsp got %b %h %h %b exp 1000 00000000 5a 1", rv, d, k, e); end
  endtask

  task automatic test_flush();
    int seen;
    logic [N-1:0] rdy, rv; int lat, en; logic [31:0] d; logic [7:0] k; logic e;
    bus.req_op[2] = OP_MUL; bus.req_key[2] = 8'h66; bus.req_a[2] = 32'd7; bus.req_b[2] = 32'd6;
    bus.req_valid = 4'b0100; bus.rsp_ready = '1;
    #1;
    n_chk++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL flush_grant got %b exp 0100", bus.req_ready); end
    tick(); bus.req_valid = '0;
    n_chk++; if (alu_en !== 1'b1) begin n_fail++; $display("FAIL flush_exec_en got %b exp 1", alu_en); end
    tick(); flush = 1'b1;
    tick(); flush = 1'b0; #1;
    n_chk++; if ({alu_clr, alu_en, bus.rsp_valid} !== {1'b1, 1'b0, 4'b0000}) begin n_fail++; $display("FAIL flush_clr got %b%b %b exp 10 0000", alu_clr, alu_en, bus.rsp_valid); end
    tick();
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.rsp_valid != '0 || alu_clr) seen++;
      tick();
    end
    n_chk++; if (seen != 0) begin n_fail++; $display("FAIL flush_quiet got %0d cycles active exp 0", seen); end
    issue(1, OP_ADD, 8'h77, 32'd2, 32'd3, rdy, lat, en, rv, d, k, e);
    n_chk++; if ({rv, d, k, e} !== {4'b0010, 32'd5, 8'h77, 1'b0} || lat != 2) begin n_fail++; $display("FAIL flush_after_add got %b %h %h %b lat %0d exp 0010 00000005 77 0 2", rv, d, k, e, lat); end
    // flush while idle: no grant that cycle, one clear cycle, then the request goes through
    bus.req_op[0] = OP_ADD; bus.req_valid = 4'b0001; flush = 1'b1; #1;
    n_chk++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_flush_nogrant got %b exp 0000", bus.req_ready); end
    tick(); flush = 1'b0; #1;
    n_chk++; if ({alu_clr, bus.req_ready} !== {1'b1, 4'b0000}) begin n_fail++; $display("FAIL idle_flush_clr got %b %b exp 1 0000", alu_clr, bus.req_ready); end
    tick();
    n_chk++; if ({alu_clr, bus.req_ready} !== {1'b0, 4'b0001}) begin n_fail++; $display("FAIL idle_flush_resume got %b %b exp 0 0001", alu_clr, bus.req_ready); end
    tick(); bus.req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_op();
    int seen;
    bus.req_op[3] = OP_MUL; bus.req_key[3] = 8'h99; bus.req_a[3] = 32'd3; bus.req_b[3] = 32'd3;
    bus.req_valid = 4'b1000; bus.rsp_ready = '1;
    tick(); bus.req_valid = '0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; ptr_m = 0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.rsp_valid != '0 || alu_en || alu_clr) seen++;
      tick();
    end
    n_chk++; if (seen != 0) begin n_fail++; $display("FAIL rst_mid_quiet got %0d cycles active exp 0", seen); end
  endtask

  function automatic logic [7:0] rand_op();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return OP_ADD;
    if (r < 6) return OP_SUB;
    if (r < 8) return OP_MUL;
    return 8'($urandom_range(4, 255));
  endfunction

  task automatic test_random();
    logic [N-1:0] gl, exp_rdy;
    int busy, wb, cur, gcyc, seen, en_cnt, nops, pick, elat, een;
    logic [31:0] ed; logic [7:0] ek; logic ee;
    do_reset();
    busy = 0; nops = 0; seen = 0; en_cnt = 0; cur = 0; gcyc = 0; gl = '0;
    ed = '0; ek = '0; ee = 1'b0; elat = 0; een = 0;
    for (int cyc = 0; cyc < 4000 && nops < 200; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (gl[i]) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
          bus.req_op[i] = rand_op(); bus.req_key[i] = 8'($urandom);
          bus.req_a[i] = $urandom; bus.req_b[i] = $urandom; bus.req_valid[i] = 1'b1;
        end else if (bus.req_valid[i] && $urandom_range(0, 15) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      gl = '0;
      bus.rsp_ready = N'($urandom);
      #1;
      wb = busy;
      if (bus.rsp_valid != '0) begin
        n_chk++; if (wb == 0 || bus.rsp_valid !== onehot(cur) || {bus.rsp_data, bus.rsp_key, bus.rsp_err} !== {ed, ek, ee}) begin n_fail++; $display("FAIL rnd_rsp got %b %h %h %b exp %b %h %h %b", bus.rsp_valid, bus.rsp_data, bus.rsp_key, bus.rsp_err, onehot(cur), ed, ek, ee); end
        if (wb != 0 && seen == 0) begin
          seen = 1;
          n_chk++; if (cyc - gcyc != elat || en_cnt != een) begin n_fail++; $display("FAIL rnd_timing got lat %0d en %0d exp %0d %0d", cyc - gcyc, en_cnt, elat, een); end
        end
        if (wb != 0 && bus.rsp_ready[cur]) begin busy = 0; nops++; end
      end else if (wb != 0) begin
        en_cnt += int'(alu_en);
      end
      if (wb == 0) begin
        pick = rr_pick(bus.req_valid, ptr_m);
        exp_rdy = onehot(pick);
        n_chk++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_grant got %b exp %b", bus.req_ready, exp_rdy); end
        if (pick >= 0) begin
          ref_op(bus.req_op[pick], bus.req_a[pick], bus.req_b[pick], ed, ee, elat, een);
          ek = bus.req_key[pick];
          busy = 1; cur = pick; gcyc = cyc; seen = 0; en_cnt = 0;
          ptr_m = (pick + 1) % N; gl[pick] = 1'b1;
        end
      end else begin
        n_chk++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL rnd_busy_grant got %b exp 0000", bus.req_ready); end
      end
    end
    bus.req_valid = '0;
    n_chk++; if (nops < 200) begin n_fail++; $display("FAIL rnd_progress got %0d ops exp 200", nops); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.req_valid = '0; bus.rsp_ready = '0;
    bus.req_op = '0; bus.req_key = '0; bus.req_a = '0; bus.req_b = '0;
    test_reset();
    test_add();
    test_sub_wrap();
    test_mul();
    test_rr();
    test_backpressure_badop();
    test_flush();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
